// File: rtl/uart_mem_transfer_ctrl_if.sv
// Bundle of the UART word-layer, memory-port and core-start signals seen by the
// load/run/dump sequencer. The master side is the sequencer itself.
interface uart_mem_transfer_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  rx_done;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  new_rx_data;
  logic                  tx_ready;
  logic                  tx_start_n;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  proc_start;
  logic                  proc_done;
  logic                  busy;
  logic                  err;

  modport master (
    input  rx_done, rx_data, new_rx_data, tx_ready, mem_rdata, proc_done,
    output tx_start_n, tx_data, mem_addr, mem_we, mem_wdata, proc_start, busy, err
  );

  modport slave (
    output rx_done, rx_data, new_rx_data, tx_ready, mem_rdata, proc_done,
    input  tx_start_n, tx_data, mem_addr, mem_we, mem_wdata, proc_start, busy, err
  );
endinterface

// File: rtl/uart_mem_transfer_ctrl.sv
// Load/run/dump sequencer: stores received UART words into shared memory, starts
// the cores, waits for them, then streams a memory window back out through the
// encoder's active-low start handshake.
module uart_mem_transfer_ctrl #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LOAD_BASE  = 0,
  parameter int unsigned LOAD_WORDS = 4,
  parameter int unsigned DUMP_BASE  = 0,
  parameter int unsigned DUMP_WORDS = 4
) (
  input logic                     clk,
  input logic                     rst,
  uart_mem_transfer_ctrl_if.master bus
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [CntW-1:0]       LoadLast = CntW'(LOAD_WORDS - 1);
  localparam logic [CntW-1:0]       DumpLast = CntW'(DUMP_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] LoadBase = ADDR_WIDTH'(LOAD_BASE);
  localparam logic [ADDR_WIDTH-1:0] DumpBase = ADDR_WIDTH'(DUMP_BASE);

  typedef enum logic [3:0] {
    StIdle, StLWait, StLWrite, StLDone, StRun,
    StDAddr, StDData, StDStart, StDGap, StDWait
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  err_q, err_d;
  logic                  first_q;  // high only in the first D_DATA cycle

  // Next-state, counter, address and error-flag logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        addr_d = LoadBase;
        if (bus.new_rx_data) state_d = StLWait;
      end
      StLWait: begin
        // Address is set up here so it is stable during the write cycle.
        if (bus.rx_done) begin
          state_d = StLWrite;
          addr_d  = LoadBase + cnt_q[ADDR_WIDTH-1:0];
        end
      end
      StLWrite: begin
        if (cnt_q == LoadLast) begin
          state_d = StLDone;
        end else begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = StLWait;
        end
      end
      StLDone: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        if (bus.rx_done) err_d = 1'b1;
        if (bus.proc_done) begin
          state_d = StDAddr;
          addr_d  = DumpBase + cnt_q[ADDR_WIDTH-1:0];
        end
      end
      StDAddr: state_d = StDData;
      StDData: begin
        // Synchronous read: data for the D_ADDR address is valid now.
        if (first_q) tx_data_d = bus.mem_rdata;
        if (bus.tx_ready && !bus.new_rx_data) state_d = StDStart;
      end
      StDStart: state_d = StDGap;
      StDGap: begin
        if (bus.rx_done || bus.new_rx_data) err_d = 1'b1;
        state_d = StDWait;
      end
      StDWait: begin
        if (bus.rx_done || bus.new_rx_data) err_d = 1'b1;
        if (bus.tx_ready) begin
          if (cnt_q == DumpLast) begin
            state_d = StIdle;
          end else begin
            cnt_d   = cnt_q + CntW'(1);
            addr_d  = DumpBase + cnt_d[ADDR_WIDTH-1:0];
            state_d = StDAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      first_q   <= (state_q == StDAddr);
    end
  end

  assign bus.mem_we     = (state_q == StLWrite);
  assign bus.mem_wdata  = (state_q == StLWrite) ? bus.rx_data : '0;
  assign bus.mem_addr   = addr_q;
  assign bus.proc_start = (state_q == StLDone);
  assign bus.tx_start_n = (state_q != StDStart);
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_uart_mem_transfer_ctrl.sv
// Directed bench: DUT A (load 4 @0x08, dump 4 @0x20) and DUT B (load 1 @0xFF,
// dump 2 @0xFF wrapping to 0x00), each with a synchronous-read memory model.
module tb_uart_mem_transfer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0;
  logic [11:0] pre_data = '0;

  uart_mem_transfer_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) ia ();
  uart_mem_transfer_ctrl_if #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) ib ();

  uart_mem_transfer_ctrl #(
    .DATA_WIDTH(12), .ADDR_WIDTH(8), .LOAD_BASE(8), .LOAD_WORDS(4),
    .DUMP_BASE(32), .DUMP_WORDS(4)
  ) u_a (.clk(clk), .rst(rst), .bus(ia));

  uart_mem_transfer_ctrl #(
    .DATA_WIDTH(12), .ADDR_WIDTH(8), .LOAD_BASE(255), .LOAD_WORDS(1),
    .DUMP_BASE(255), .DUMP_WORDS(2)
  ) u_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;

  logic [11:0] mem_a [256];
  logic [11:0] mem_b [256];

  always @(posedge clk) begin
    if (ia.mem_we) mem_a[ia.mem_addr] <= ia.mem_wdata;
    else if (pre_we) mem_a[pre_addr] <= pre_data;
    ia.mem_rdata <= mem_a[ia.mem_addr];
  end

  always @(posedge clk) begin
    if (ib.mem_we) mem_b[ib.mem_addr] <= ib.mem_wdata;
    else if (pre_we) mem_b[pre_addr] <= pre_data;
    ib.mem_rdata <= mem_b[ib.mem_addr];
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [11:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  // One encoder word into DUT A; checks the write cycle right after rx_done.
  task automatic a_load_word(input int k, input logic [11:0] d);
    ia.new_rx_data = 1'b1;
    tick();
    ia.new_rx_data = 1'b0;
    tick();
    tick();
    ia.rx_done = 1'b1; ia.rx_data = d;
    tick();
    ia.rx_done = 1'b0;
    check("a_load_we", ia.mem_we, 1);
    check("a_load_addr", ia.mem_addr, 32'(8 + k));
    check("a_load_wdata", ia.mem_wdata, d);
    check("a_load_busy", ia.busy, 1);
  endtask

  // Called in D_ADDR; optionally stalls tx_ready in D_DATA and injects new_rx_data in D_WAIT.
  task automatic a_tx(input int k, input logic [11:0] exp, input bit hold, input bit inject);
    bit bad;
    check("a_dump_addr", ia.mem_addr, 32'(32 + k));
    ia.tx_ready = !hold;
    tick();
    if (hold) begin
      bad = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (ia.tx_start_n !== 1'b1 || ia.tx_data !== exp) bad = 1'b1;
      end
      check("a_hold_no_start", 32'(bad), 0);
      ia.tx_ready = 1'b1;
    end
    tick();
    check("a_tx_start_n_low", ia.tx_start_n, 0);
    check("a_tx_data", ia.tx_data, exp);
    ia.tx_ready = 1'b0;
    tick();
    check("a_tx_start_n_pulse", ia.tx_start_n, 1);
    tick();
    if (inject) begin
      ia.new_rx_data = 1'b1;
      tick();
      ia.new_rx_data = 1'b0;
      check("a_err_dwait", ia.err, 1);
    end else begin
      tick();
    end
    ia.tx_ready = 1'b1;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ia.rx_done = 0; ia.rx_data = 0; ia.new_rx_data = 0; ia.tx_ready = 1; ia.proc_done = 0;
    ib.rx_done = 0; ib.rx_data = 0; ib.new_rx_data = 0; ib.tx_ready = 1; ib.proc_done = 0;
    rst = 1'b1;
    tick();
    preload(8'h20, 12'h0F0);
    preload(8'h21, 12'h0F1);
    preload(8'h22, 12'h0F2);
    preload(8'h23, 12'h0F3);
    preload(8'h00, 12'h5A5);
    tick();
    check("rst_busy", ia.busy, 0);
    check("rst_tx_start_n", ia.tx_start_n, 1);
    check("rst_tx_data", ia.tx_data, 0);
    check("rst_mem_addr", ia.mem_addr, 0);
    check("rst_mem_we", ia.mem_we, 0);
    check("rst_proc_start", ia.proc_start, 0);
    check("rst_err", ia.err, 0);
    rst = 1'b0;

    // Load four words, then proc_start one cycle after the last write.
    a_load_word(0, 12'h123);
    a_load_word(1, 12'h456);
    a_load_word(2, 12'h789);
    a_load_word(3, 12'hABC);
    tick();
    check("a_proc_start", ia.proc_start, 1);
    tick();
    check("a_proc_start_once", ia.proc_start, 0);
    check("a_run_busy", ia.busy, 1);

    // rx_done in RUN flags an error and writes nothing.
    ia.rx_done = 1'b1;
    tick();
    ia.rx_done = 1'b0;
    check("a_err_run", ia.err, 1);
    check("a_run_no_we", ia.mem_we, 0);
    tick();
    check("a_mem8", mem_a[8], 12'h123);
    check("a_mem9", mem_a[9], 12'h456);
    check("a_mem10", mem_a[10], 12'h789);
    check("a_mem11", mem_a[11], 12'hABC);

    // Dump four words.
    ia.proc_done = 1'b1;
    tick();
    ia.proc_done = 1'b0;
    a_tx(0, 12'h0F0, 1'b0, 1'b0);
    a_tx(1, 12'h0F1, 1'b1, 1'b1);
    a_tx(2, 12'h0F2, 1'b0, 1'b0);
    a_tx(3, 12'h0F3, 1'b0, 1'b0);
    check("a_idle_busy", ia.busy, 0);
    check("a_err_sticky", ia.err, 1);
    check("a_idle_tx_start_n", ia.tx_start_n, 1);

    // Reset in the middle of load word 2, then restart from LOAD_BASE.
    a_load_word(0, 12'h321);
    ia.new_rx_data = 1'b1;
    tick();
    ia.new_rx_data = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", ia.busy, 0);
    check("mid_rst_err", ia.err, 0);
    check("mid_rst_tx_data", ia.tx_data, 0);
    check("mid_rst_mem_addr", ia.mem_addr, 0);
    check("mid_rst_mem_we", ia.mem_we, 0);
    check("mid_rst_wdata", ia.mem_wdata, 0);
    check("mid_rst_proc_start", ia.proc_start, 0);
    check("mid_rst_tx_start_n", ia.tx_start_n, 1);
    a_load_word(0, 12'h654);
    tick();
    check("restart_mem8", mem_a[8], 12'h654);
    check("restart_mem9", mem_a[9], 12'h456);

    // DUT B: single load at 0xFF, dump 0xFF then wrap to 0x00.
    ib.new_rx_data = 1'b1;
    tick();
    ib.new_rx_data = 1'b0;
    tick();
    ib.rx_done = 1'b1; ib.rx_data = 12'h3C3;
    tick();
    ib.rx_done = 1'b0;
    check("b_we", ib.mem_we, 1);
    check("b_addr", ib.mem_addr, 32'h0FF);
    check("b_wdata", ib.mem_wdata, 12'h3C3);
    tick();
    check("b_proc_start", ib.proc_start, 1);
    tick();
    check("b_proc_start_once", ib.proc_start, 0);
    ib.proc_done = 1'b1;
    tick();
    ib.proc_done = 1'b0;
    check("b_dump_addr0", ib.mem_addr, 32'h0FF);
    for (int i = 0; i < 20 && ib.tx_start_n !== 1'b0; i++) tick();
    check("b_start0", ib.tx_start_n, 0);
    check("b_data0", ib.tx_data, 12'h3C3);
    tick();
    tick();
    tick();
    check("b_dump_addr_wrap", ib.mem_addr, 32'h000);
    for (int i = 0; i < 20 && ib.tx_start_n !== 1'b0; i++) tick();
    check("b_start1", ib.tx_start_n, 0);
    check("b_data1", ib.tx_data, 12'h5A5);
    tick();
    tick();
    tick();
    check("b_idle", ib.busy, 0);
    check("b_err", ib.err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
